// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit - program-counter unit for the single-cycle RISC-V core.
//
// Holds the registered program counter and selects the next PC. The choices
// are sequential, PC-relative (branch/JAL), register-relative (JALR) or trap
// return. It also handles stall hold and trap entry, and saves the exception
// PC on a trap. The link value (pc + STEP) and the computed redirect target
// are exported combinationally for the register-file write-back mux.
//
// Ports:
//   clk        in   1     clock, all state updates on the rising edge
//   rst        in   1     synchronous active-high reset, highest priority
//   en         in   1     advance enable (0 = stall, state holds, trap drops)
//   pc_src     in   2     00 seq, 01 PC-relative, 10 JALR, 11 trap return
//   take       in   1     branch condition, qualifies pc_src = 01
//   imm        in   XLEN  sign-extended immediate
//   rs1        in   XLEN  register operand for JALR
//   ext_trap   in   1     trap request from decode
//   pc         out  XLEN  current PC (registered)
//   pc_plus    out  XLEN  pc + STEP (combinational link value)
//   target     out  XLEN  computed redirect target (combinational)
//   epc        out  XLEN  saved exception PC (registered)
//   trap       out  1     one-cycle pulse, trap entered on the last edge
//   trap_cause out  2     00 none, 01 misaligned target, 10 external (sticky)
// -----------------------------------------------------------------------------
module pc_unit #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int unsigned     STEP         = 4,
   parameter int unsigned     ALIGN_BITS   = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [1:0]      pc_src,
   input  logic            take,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1,
   input  logic            ext_trap,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus,
   output logic [XLEN-1:0] target,
   output logic [XLEN-1:0] epc,
   output logic            trap,
   output logic [1:0]      trap_cause
);

   // Next-PC source encodings
   localparam logic [1:0] SRC_SEQ  = 2'b00;
   localparam logic [1:0] SRC_REL  = 2'b01;
   localparam logic [1:0] SRC_JALR = 2'b10;
   localparam logic [1:0] SRC_RET  = 2'b11;

   // Trap cause encodings
   localparam logic [1:0] CAUSE_NONE  = 2'b00;
   localparam logic [1:0] CAUSE_ALIGN = 2'b01;
   localparam logic [1:0] CAUSE_EXT   = 2'b10;

   localparam logic [XLEN-1:0] STEP_W = XLEN'(STEP);

   // True when any of the low ALIGN_BITS address bits is set
   function automatic logic misaligned_f(input logic [XLEN-1:0] addr);
      return |addr[ALIGN_BITS-1:0];
   endfunction

   logic [XLEN-1:0] pc_r;
   logic [XLEN-1:0] epc_r;
   logic            trap_r;
   logic [1:0]      cause_r;

   logic [XLEN-1:0] pc_plus_s;
   logic [XLEN-1:0] rel_sum_s;
   logic [XLEN-1:0] jalr_sum_s;
   logic [XLEN-1:0] target_s;
   logic            redirect_s;
   logic            misaligned_s;

   logic [XLEN-1:0] pc_nxt_s;
   logic [XLEN-1:0] epc_nxt_s;
   logic            trap_nxt_s;
   logic [1:0]      cause_nxt_s;

   // Adders: all wrap modulo 2^XLEN with no carry out
   always_comb begin
      pc_plus_s  = pc_r + STEP_W;
      rel_sum_s  = pc_r + imm;
      jalr_sum_s = rs1 + imm;
   end

   // Target mux. JALR clears bit 0 before the alignment check sees it.
   always_comb begin
      target_s = pc_plus_s;
      case (pc_src)
         SRC_SEQ:  target_s = pc_plus_s;
         SRC_REL:  target_s = rel_sum_s;
         SRC_JALR: target_s = {jalr_sum_s[XLEN-1:1], 1'b0};
         SRC_RET:  target_s = epc_r;
         default:  target_s = pc_plus_s;
      endcase
   end

   // Redirect decision and alignment check. An untaken branch is sequential,
   // so its target is never checked.
   always_comb begin
      redirect_s = 1'b0;
      case (pc_src)
         SRC_SEQ:  redirect_s = 1'b0;
         SRC_REL:  redirect_s = take;
         SRC_JALR: redirect_s = 1'b1;
         SRC_RET:  redirect_s = 1'b1;
         default:  redirect_s = 1'b0;
      endcase
      if (redirect_s) begin
         misaligned_s = misaligned_f(target_s);
      end else begin
         misaligned_s = 1'b0;
      end
   end

   // Next-state selection: external trap beats misaligned trap beats redirect.
   // A stall holds everything except trap, which is a one-cycle pulse.
   always_comb begin
      pc_nxt_s    = pc_r;
      epc_nxt_s   = epc_r;
      trap_nxt_s  = 1'b0;
      cause_nxt_s = cause_r;
      if (!en) begin
         pc_nxt_s    = pc_r;
         epc_nxt_s   = epc_r;
         trap_nxt_s  = 1'b0;
         cause_nxt_s = cause_r;
      end else if (ext_trap) begin
         pc_nxt_s    = TRAP_VECTOR;
         epc_nxt_s   = pc_r;
         trap_nxt_s  = 1'b1;
         cause_nxt_s = CAUSE_EXT;
      end else if (misaligned_s) begin
         pc_nxt_s    = TRAP_VECTOR;
         epc_nxt_s   = pc_r;
         trap_nxt_s  = 1'b1;
         cause_nxt_s = CAUSE_ALIGN;
      end else if (redirect_s) begin
         pc_nxt_s    = target_s;
         epc_nxt_s   = epc_r;
         trap_nxt_s  = 1'b0;
         cause_nxt_s = cause_r;
      end else begin
         pc_nxt_s    = pc_plus_s;
         epc_nxt_s   = epc_r;
         trap_nxt_s  = 1'b0;
         cause_nxt_s = cause_r;
      end
   end

   // State registers with synchronous reset taking priority over everything
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r    <= RESET_VECTOR;
         epc_r   <= {XLEN{1'b0}};
         trap_r  <= 1'b0;
         cause_r <= CAUSE_NONE;
      end else begin
         pc_r    <= pc_nxt_s;
         epc_r   <= epc_nxt_s;
         trap_r  <= trap_nxt_s;
         cause_r <= cause_nxt_s;
      end
   end

   assign pc         = pc_r;
   assign pc_plus    = pc_plus_s;
   assign target     = target_s;
   assign epc        = epc_r;
   assign trap       = trap_r;
   assign trap_cause = cause_r;

endmodule
